// File: rtl/gate_sensor_fsm_if.sv
// Pulse interface between the barrier sensor front end and parking_ctrl.
// The sensor FSM is the producer (master); parking_ctrl is the consumer (slave)
// and supplies the occupancy status back as `full`.
interface gate_sensor_fsm_if;
    logic full;
    logic entry_pulse;
    logic exit_pulse;
    logic reject_pulse;
    logic busy;
    logic fault;

    modport master (
        input  full,
        output entry_pulse,
        output exit_pulse,
        output reject_pulse,
        output busy,
        output fault
    );

    modport slave (
        output full,
        input  entry_pulse,
        input  exit_pulse,
        input  reject_pulse,
        input  busy,
        input  fault
    );
endinterface

// File: rtl/gate_sensor_fsm.sv
// Barrier beam-break front end: synchronises and debounces the outer (a) and
// inner (b) beams, follows the vehicle through the a/b overlap sequence and
// emits one-cycle entry / exit / reject strobes. Malformed sequences and
// vehicles that stall inside the barrier raise a fault that clears when both
// beams are clear again.
module gate_sensor_fsm #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sensor_a,
    input  logic              sensor_b,
    gate_sensor_fsm_if.master pulse
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_AB,
        OUT_A,
        FAULT
    } state_t;

    // Bit 1 carries the outer beam (a), bit 0 the inner beam (b).
    logic [1:0] raw;
    logic [1:0] db;

    assign raw = {sensor_a, sensor_b};

    // Identical synchroniser + debounce channel for each beam.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic [DB_W-1:0] cnt_reg;

            // 2-FF synchroniser, then count consecutive samples that disagree
            // with the debounced level; adopt the new level after enough of them.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign db[gi] = db_reg;
        end
    endgenerate

    state_t          state_reg;
    state_t          state_next;
    logic [TO_W-1:0] tmo_reg;
    logic [TO_W-1:0] tmo_next;
    logic            entry_reg;
    logic            entry_next;
    logic            exit_reg;
    logic            exit_next;
    logic            reject_reg;
    logic            reject_next;
    logic            busy_reg;
    logic            fault_reg;

    // Sequence transitions on the debounced pair {a,b}; a level matching the
    // current state's own pattern leaves the state unchanged. The stall
    // counter only runs while a vehicle sits in one transit state.
    always_comb begin
        state_next  = state_reg;
        tmo_next    = '0;
        entry_next  = 1'b0;
        exit_next   = 1'b0;
        reject_next = 1'b0;

        case (state_reg)
            IDLE: begin
                case (db)
                    2'b10:   state_next = IN_A;
                    2'b01:   state_next = OUT_B;
                    2'b11:   state_next = FAULT;
                    default: ;
                endcase
            end
            IN_A: begin
                case (db)
                    2'b11:   state_next = IN_AB;
                    2'b00:   state_next = IDLE;
                    2'b01:   state_next = FAULT;
                    default: ;
                endcase
            end
            IN_AB: begin
                case (db)
                    2'b01:   state_next = IN_B;
                    2'b10:   state_next = IN_A;
                    2'b00:   state_next = FAULT;
                    default: ;
                endcase
            end
            IN_B: begin
                case (db)
                    2'b00: begin
                        state_next = IDLE;
                        if (pulse.full) begin
                            reject_next = 1'b1;
                        end else begin
                            entry_next = 1'b1;
                        end
                    end
                    2'b11:   state_next = IN_AB;
                    2'b10:   state_next = FAULT;
                    default: ;
                endcase
            end
            OUT_B: begin
                case (db)
                    2'b11:   state_next = OUT_AB;
                    2'b00:   state_next = IDLE;
                    2'b10:   state_next = FAULT;
                    default: ;
                endcase
            end
            OUT_AB: begin
                case (db)
                    2'b10:   state_next = OUT_A;
                    2'b01:   state_next = OUT_B;
                    2'b00:   state_next = FAULT;
                    default: ;
                endcase
            end
            OUT_A: begin
                case (db)
                    2'b00: begin
                        state_next = IDLE;
                        exit_next  = 1'b1;
                    end
                    2'b11:   state_next = OUT_AB;
                    2'b01:   state_next = FAULT;
                    default: ;
                endcase
            end
            FAULT: begin
                if (db == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_reg != IDLE && state_reg != FAULT && state_next == state_reg) begin
            if (tmo_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_next = FAULT;
            end else begin
                tmo_next = tmo_reg + TO_W'(1);
            end
        end
    end

    // State, stall counter and all status outputs registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            tmo_reg    <= '0;
            entry_reg  <= 1'b0;
            exit_reg   <= 1'b0;
            reject_reg <= 1'b0;
            busy_reg   <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tmo_reg    <= tmo_next;
            entry_reg  <= entry_next;
            exit_reg   <= exit_next;
            reject_reg <= reject_next;
            busy_reg   <= (state_next != IDLE);
            fault_reg  <= (state_next == FAULT);
        end
    end

    assign pulse.entry_pulse  = entry_reg;
    assign pulse.exit_pulse   = exit_reg;
    assign pulse.reject_pulse = reject_reg;
    assign pulse.busy         = busy_reg;
    assign pulse.fault        = fault_reg;

endmodule

// File: tb/tb_gate_sensor_fsm.sv
// Self-checking bench for gate_sensor_fsm: directed scenarios followed by
// random beam sequences scored against a path-position reference model.
module tb_gate_sensor_fsm;
    localparam int DB  = 4;
    localparam int TMO = 200;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_entry = 0, n_exit = 0, n_reject = 0, n_busy = 0, n_fault = 0;
    int last_entry_cyc = -1, last_exit_cyc = -1;
    int drive_cyc = 0;
    int e0 = 0, x0 = 0, r0 = 0, b0 = 0, f0 = 0;
    logic [1:0] seq_q[$];

    gate_sensor_fsm_if pif();

    gate_sensor_fsm #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .pulse   (pif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse/status monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (pif.entry_pulse === 1'b1) begin
            n_entry++;
            last_entry_cyc = cyc;
        end
        if (pif.exit_pulse === 1'b1) begin
            n_exit++;
            last_exit_cyc = cyc;
        end
        if (pif.reject_pulse === 1'b1) n_reject++;
        if (pif.busy === 1'b1) n_busy++;
        if (pif.fault === 1'b1) n_fault++;
        if (pif.entry_pulse === 1'b1 || pif.exit_pulse === 1'b1 || pif.reject_pulse === 1'b1)
            check("pulse_exclusive",
                  32'(pif.entry_pulse) + 32'(pif.exit_pulse) + 32'(pif.reject_pulse), 1);
    end

    task automatic hold(input logic a, input logic b, input int n);
        sensor_a  = a;
        sensor_b  = b;
        drive_cyc = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic scn_begin();
        e0 = n_entry; x0 = n_exit; r0 = n_reject; b0 = n_busy; f0 = n_fault;
    endtask

    // Let the sensors settle clear, then compare pulse counts and idle status.
    task automatic scn_end(input string tag, input int ee, input int ex, input int er);
        hold(1'b0, 1'b0, DB + 10);
        check({tag, "_entry"},  n_entry - e0,  ee);
        check({tag, "_exit"},   n_exit - x0,   ex);
        check({tag, "_reject"}, n_reject - r0, er);
        check({tag, "_busy"},   pif.busy,      0);
        check({tag, "_fault"},  pif.fault,     0);
    endtask

    // Position of a level along the entry track 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] track_at(input int p);
        case (p)
            1:       return 2'b10;
            2:       return 2'b11;
            3:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Reference model: a vehicle moves one step at a time along its track
    // (exit track = entry track with a and b swapped); any jump is a fault.
    function automatic void model_seq(input logic fl, output int e, output int x,
                                      output int r, output bit f_any);
        int mode = 0;  // 0 clear, 1 entering, 2 leaving, 3 fault
        int pos  = 0;
        logic [1:0] prev = 2'b00;
        logic [1:0] v;
        e = 0; x = 0; r = 0; f_any = 1'b0;
        foreach (seq_q[i]) begin
            if (seq_q[i] == prev) continue;
            prev = seq_q[i];
            if (mode == 3) begin
                if (prev == 2'b00) mode = 0;
            end else if (mode == 0) begin
                if (prev == 2'b10) begin
                    mode = 1; pos = 1;
                end else if (prev == 2'b01) begin
                    mode = 2; pos = 1;
                end else begin
                    mode = 3; f_any = 1'b1;
                end
            end else begin
                v = (mode == 1) ? prev : {prev[0], prev[1]};
                if (v == track_at(pos + 1)) pos++;
                else if (v == track_at(pos - 1)) pos--;
                else begin
                    mode = 3; f_any = 1'b1;
                end
                if (mode != 3 && pos == 4) begin
                    if (mode == 1) begin
                        if (fl) r++;
                        else e++;
                    end else begin
                        x++;
                    end
                    mode = 0;
                end else if (mode != 3 && pos == 0) begin
                    mode = 0;
                end
            end
        end
    endfunction

    initial begin
        int rel;
        int me, mx, mr;
        bit mf;
        pif.full = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_entry",  pif.entry_pulse,  0);
        check("rst_exit",   pif.exit_pulse,   0);
        check("rst_reject", pif.reject_pulse, 0);
        check("rst_busy",   pif.busy,         0);
        check("rst_fault",  pif.fault,        0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", pif.busy, 0);

        // Valid entry with latency check
        scn_begin();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 12);
        rel = drive_cyc;
        check("entry_latency", last_entry_cyc - rel, DB + 3);
        scn_end("entry", 1, 0, 0);

        // Valid exit with latency check
        scn_begin();
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 12);
        rel = drive_cyc;
        check("exit_latency", last_exit_cyc - rel, DB + 3);
        scn_end("exit", 0, 1, 0);

        // Abort
        scn_begin();
        hold(1'b1, 1'b0, 10);
        check("abort_busy", pif.busy, 1);
        scn_end("abort", 0, 0, 0);
        check("abort_nofault", n_fault - f0, 0);

        // Back-out
        scn_begin();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        scn_end("backout", 0, 0, 0);

        // Entry and exit while full
        pif.full = 1'b1;
        scn_begin();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        scn_end("full_entry", 0, 0, 1);
        scn_begin();
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        scn_end("full_exit", 0, 1, 0);
        pif.full = 1'b0;

        // Debounce: short glitches ignored, a 6-cycle hold is seen
        scn_begin();
        repeat (5) begin
            hold(1'b1, 1'b0, 3);
            hold(1'b0, 1'b0, 6);
        end
        hold(1'b0, 1'b0, 10);
        check("glitch_busy", n_busy - b0, 0);
        scn_begin();
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b0, 20);
        check("hold6_busy_seen", 32'(n_busy > b0), 1);
        scn_end("hold6", 0, 0, 0);

        // Both beams together from idle
        scn_begin();
        hold(1'b1, 1'b1, 20);
        check("both_fault", pif.fault, 1);
        check("both_busy",  pif.busy,  1);
        scn_end("both", 0, 0, 0);

        // Stall in IN_A
        scn_begin();
        hold(1'b1, 1'b0, 100);
        check("tmo_early_fault", pif.fault, 0);
        check("tmo_early_busy",  pif.busy,  1);
        hold(1'b1, 1'b0, 150);
        check("tmo_fault", pif.fault, 1);
        scn_end("tmo", 0, 0, 0);

        // Reset in the middle of IN_AB
        scn_begin();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        check("midrst_pre_busy", pif.busy, 1);
        rst_n    = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy",  pif.busy,  0);
        check("midrst_fault", pif.fault, 0);
        scn_end("midrst", 0, 0, 0);
        scn_begin();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        scn_end("post_rst_entry", 1, 0, 0);

        // Random sequences against the reference model
        for (int t = 0; t < 16; t++) begin
            int len;
            logic fl;
            seq_q.delete();
            len = $urandom_range(2, 6);
            for (int k = 0; k < len; k++) seq_q.push_back(2'($urandom_range(0, 3)));
            seq_q.push_back(2'b00);
            fl = 1'($urandom_range(0, 1));
            pif.full = fl;
            model_seq(fl, me, mx, mr, mf);
            scn_begin();
            foreach (seq_q[i]) hold(seq_q[i][1], seq_q[i][0], $urandom_range(8, 30));
            scn_end($sformatf("rand%0d", t), me, mx, mr);
            check($sformatf("rand%0d_fault_seen", t), 32'(n_fault > f0), 32'(mf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_sensor_fsm.md
# gate_sensor_fsm

Converts two raw beam-break sensors at the car-park barrier into the one-cycle `entry_pulse` / `exit_pulse` strobes consumed by `parking_ctrl`. It is the producer side of that pulse interface. It synchronises and debounces both sensors, tracks vehicle direction with a sequence FSM, and suppresses entries when `parking_ctrl` reports `full`. It also flags malformed or stalled sequences.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples required before a debounced sensor value changes (≥1).
- `TIMEOUT_CYCLES`, 100000: maximum cycles allowed in any transit state before a fault (≥2).
- `clk`  in  1  system clock, 100 MHz, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sensor_a`  in  1  outer beam, asynchronous, 1 = beam broken.
- `sensor_b`  in  1  inner beam, asynchronous, 1 = beam broken.
- `full`  in  1  from `parking_ctrl`; 1 = no spaces.
- `entry_pulse`  out  1  one-cycle strobe, one valid entry.
- `exit_pulse`  out  1  one-cycle strobe, one valid exit.
- `reject_pulse`  out  1  one-cycle strobe, entry completed while `full`.
- `busy`  out  1  FSM not in IDLE.
- `fault`  out  1  sticky sequence/timeout error; clears on return to IDLE.

## Operation
- Reset (`rst_n`=0 at a posedge):
  - synchroniser flops, debounced `a_db`/`b_db`, and debounce and timeout counters = 0.
  - state = IDLE.
  - all outputs = 0.
- Synchroniser: 2-FF per sensor.
- Debounce, per sensor independently:
  - The counter resets whenever the synced value equals the current debounced value.
  - Otherwise it increments.
  - On reaching `DEBOUNCE_CYCLES`, the debounced value takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- FSM input is `{a_db,b_db}`. It is evaluated every cycle; no transition occurs if the input is unchanged.
  - IDLE: 10 → IN_A; 01 → OUT_B; 11 → FAULT.
  - IN_A: 11 → IN_AB; 00 → IDLE (abort, no pulse); 01 → FAULT.
  - IN_AB: 01 → IN_B; 10 → IN_A (backing out); 00 → FAULT.
  - IN_B: 00 → IDLE, completing an entry; 11 → IN_AB; 10 → FAULT.
  - OUT_B / OUT_AB / OUT_A are the mirror of the entry path with a↔b swapped. Completion OUT_A → IDLE on 00 produces `exit_pulse`.
  - FAULT: `fault`=1. Stays until input = 00, then → IDLE and `fault` is cleared on that transition.
- Entry completion:
  - `entry_pulse`=1 if `full`=0, sampled in the completing cycle.
  - Otherwise `reject_pulse`=1.
  - Never both.
- `entry_pulse` and `exit_pulse` are mutually exclusive by construction; they never assert in the same cycle.
- Timeout:
  - The counter clears on every state change and in IDLE/FAULT.
  - It increments in transit states.
  - Reaching `TIMEOUT_CYCLES` → FAULT.
- `busy` = (state ≠ IDLE), registered.

## Timing
- All outputs are registered, and every pulse is exactly 1 cycle wide.
- Latency, raw sensor edge to debounced change: 2 (sync) + `DEBOUNCE_CYCLES` cycles, provided the level is held stable.
- Latency, debounced 00 in IN_B/OUT_A to pulse high: 1 cycle. Raw final release to pulse is therefore `DEBOUNCE_CYCLES`+3 cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` synced cycles produce no state change.
- A back-to-back vehicle may start in the cycle after the pulse (IDLE → IN_A is permitted immediately).
- `rst_n` low mid-sequence aborts it on that edge: no pulse, `fault`=0, IDLE. The first cycle after release is IDLE with outputs 0.
- `full` changing mid-sequence has no effect until the completion cycle.

## Test plan
- Entry: the bench runs with `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=200. Drive sensor states a:10 → 11 → 01 → 00, holding each for 10 cycles, with `full`=0. Required: exactly one `entry_pulse`, 7 cycles after the final release, and no other pulse.
- Exit and abort:
  - Sequence 01 → 11 → 10 → 00 gives exactly one `exit_pulse`.
  - Sequence 10 → 00 (abort) gives no pulse and `fault`=0.
  - Sequence 10 → 11 → 10 → 00 (back-out) gives no pulse.
- Full: with `full`=1, a valid entry sequence gives `reject_pulse`=1 for 1 cycle and `entry_pulse`=0. A valid exit with `full`=1 still gives `exit_pulse`.
- Debounce: 3-cycle glitches on `sensor_a` while idle give `busy`=0 throughout and no pulses. A 6-cycle hold gives `busy`=1.
- Faults:
  - Both sensors rising together from idle → `fault`=1.
  - Hold 10 for 250 cycles → `fault`=1 once 200 cycles elapse in IN_A.
  - In both cases `fault` clears once sensors read 00 after debounce, and no pulses are produced.
- Reset mid-sequence: assert `rst_n`=0 for 2 cycles while in IN_AB, then release with sensors 00. Required: `busy`=0, no pulse. A subsequent full entry sequence yields exactly one `entry_pulse`.
